// File: rtl/clk_div_prog_pkg.sv
// Shared constants for the programmable clock divider: counter width and the
// divisor/duty pair loaded at reset (also used by the buzzer tone table).
package clk_div_prog_pkg;
  localparam int unsigned CDP_WIDTH        = 16;
  localparam int unsigned CDP_DEFAULT_DIV  = 2;
  localparam int unsigned CDP_DEFAULT_DUTY = 1;
endpackage

// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider. Outputs a registered divided clock
// (high for min(duty,div) cycles of each div-cycle period) and a one-cycle
// tick on each period wrap. Divisor/duty are double-buffered: a load lands in
// a shadow register and is applied only at a wrap or while stopped, so a
// period is never cut short or stretched mid-flight.
module clk_div_prog
  import clk_div_prog_pkg::*;
#(
  parameter int unsigned WIDTH        = CDP_WIDTH,
  parameter int unsigned DEFAULT_DIV  = CDP_DEFAULT_DIV,
  parameter int unsigned DEFAULT_DUTY = CDP_DEFAULT_DUTY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_in,
  input  logic [WIDTH-1:0] duty_in,
  output logic             busy,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [WIDTH-1:0] RST_DIV  = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] RST_DUTY = WIDTH'(DEFAULT_DUTY);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] div_act, duty_act;
  logic [WIDTH-1:0] div_shd, duty_shd;
  logic [WIDTH-1:0] div_m1;
  logic             stopped, wrap, apply;

  // Period-boundary decode; div_act-1 only matters when div_act is nonzero,
  // because a zero divisor forces the stopped path.
  always_comb begin
    stopped = !en || (div_act == '0);
    div_m1  = div_act - WIDTH'(1);
    wrap    = !stopped && (cnt == div_m1);
    apply   = stopped || wrap;
  end

  // Shadow/active register pair with the busy flag. A load coinciding with
  // an apply edge bypasses the shadow and goes straight to active.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_act  <= RST_DIV;
      duty_act <= RST_DUTY;
      div_shd  <= RST_DIV;
      duty_shd <= RST_DUTY;
      busy     <= 1'b0;
    end else if (apply) begin
      busy <= 1'b0;
      if (div_load) begin
        div_act  <= div_in;
        duty_act <= duty_in;
        div_shd  <= div_in;
        duty_shd <= duty_in;
      end else begin
        div_act  <= div_shd;
        duty_act <= duty_shd;
      end
    end else if (div_load) begin
      div_shd  <= div_in;
      duty_shd <= duty_in;
      busy     <= 1'b1;
    end
  end

  // Period counter and registered outputs; the duty compare uses the
  // pre-edge count so clk_out is high for cnt = 0 .. duty_act-1.
  always_ff @(posedge clk) begin
    if (rst || stopped) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      clk_out <= (cnt < duty_act);
      tick    <= wrap;
      cnt     <= wrap ? '0 : cnt + WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog. Each cycle the stimulus drives inputs and
// pushes the hand-computed post-edge {clk_out, tick, busy} into a queue; a
// monitor pops one entry after every rising edge and compares.
module tb_clk_div_prog;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, en, div_load;
  logic [W-1:0] div_in, duty_in;
  logic         busy, clk_out, tick;

  typedef struct {
    int   tnum;
    logic co;
    logic tk;
    logic bz;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cur_test = 0;

  clk_div_prog dut (
    .clk(clk), .rst(rst), .en(en), .div_load(div_load),
    .div_in(div_in), .duty_in(duty_in),
    .busy(busy), .clk_out(clk_out), .tick(tick)
  );

  always #5 clk = ~clk;

  // Monitor: outputs are presented every cycle; compare 1 time unit after
  // the edge against the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({clk_out, tick, busy} !== {e.co, e.tk, e.bz}) begin
        errors++;
        $display("FAIL test%0d t=%0t {clk_out,tick,busy} got %b%b%b want %b%b%b",
                 e.tnum, $time, clk_out, tick, busy, e.co, e.tk, e.bz);
      end
    end
  end

  // One clock: drive inputs, queue the expected post-edge outputs, take edge.
  task automatic cyc(input logic r, input logic e, input logic ld,
                     input int dv, input int dt,
                     input logic co, input logic tk, input logic bz);
    exp_t x;
    rst = r; en = e; div_load = ld;
    div_in = W'(dv); duty_in = W'(dt);
    x.tnum = cur_test; x.co = co; x.tk = tk; x.bz = bz;
    exp_q.push_back(x);
    @(posedge clk);
    #2;
  endtask

  // Run cycles with no load; pattern given as co/tk bit strings per cycle.
  task automatic run(input int n, input logic [31:0] co_pat, input logic [31:0] tk_pat);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 1'b1, 1'b0, 0, 0, co_pat[n-1-i], tk_pat[n-1-i], 1'b0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; div_load = 1'b0; div_in = '0; duty_in = '0;

    // Reset state
    cur_test = 0;
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 9, 9, 0, 0, 0);

    // 1: defaults div=2 duty=1 -> classic divide-by-2
    cur_test = 1;
    run(6, 6'b101010, 6'b010101);

    // 2: load 5/2 at cnt=0, applied at the wrap one edge later
    cur_test = 2;
    cyc(0, 1, 1, 5, 2, 1, 0, 1);
    cyc(0, 1, 0, 0, 0, 0, 1, 0);
    run(10, 10'b11000_11000, 10'b00001_00001);

    // 3: two loads before a wrap; only the last (3/1) sticks
    cur_test = 3;
    cyc(0, 1, 1, 8, 2, 1, 0, 1);
    cyc(0, 1, 1, 3, 1, 1, 0, 1);
    cyc(0, 1, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0, 1, 0);
    run(6, 6'b100_100, 6'b001_001);

    // 4a: duty=0 with div=4 -> clk_out low, tick every 4
    cur_test = 4;
    cyc(0, 1, 1, 4, 0, 1, 0, 1);
    cyc(0, 1, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0, 1, 0);
    run(8, 8'b0000_0000, 8'b0001_0001);
    // 4b: duty=10 with div=4 -> clk_out high, tick every 4
    cyc(0, 1, 1, 4, 10, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0, 1, 0);
    run(8, 8'b1111_1111, 8'b0001_0001);

    // 5: div=0 stops at the wrap; then 1/1 applies immediately
    cur_test = 5;
    cyc(0, 1, 1, 0, 0, 1, 0, 1);
    cyc(0, 1, 0, 0, 0, 1, 0, 1);
    cyc(0, 1, 0, 0, 0, 1, 0, 1);
    cyc(0, 1, 0, 0, 0, 1, 1, 0);
    run(3, 3'b000, 3'b000);
    cyc(0, 1, 1, 1, 1, 0, 0, 0);
    run(4, 4'b1111, 4'b1111);

    // 6: en drop restarts the period; reset aborts a pending load
    cur_test = 6;
    cyc(0, 1, 1, 4, 2, 1, 1, 0);
    cyc(0, 1, 0, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    run(4, 4'b1100, 4'b0001);
    cyc(0, 1, 1, 7, 3, 1, 0, 1);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    run(4, 4'b1010, 4'b0101);

    en = 1'b0;
    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain queue size got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
